// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double dabble).
// Start-pulse / done-pulse handshake around a small FSM.
module bcd_to_bin #(
  parameter int N_DIG = 2,
  parameter int W_BIN = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_init,
  input  logic [4*N_DIG-1:0] in_BCD,
  output logic [W_BIN-1:0]   out_BIN,
  output logic               out_DONE,
  output logic               out_BUSY,
  output logic               out_ERR
);

  localparam int BW = 4 * N_DIG;
  localparam int CW = (W_BIN > 1) ? $clog2(W_BIN) : 1;
  localparam logic [CW-1:0] LAST = CW'(W_BIN - 1);

  function automatic longint f_pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  if ((longint'(1) << W_BIN) < f_pow10(N_DIG)) begin : g_width_chk
    $error("bcd_to_bin: W_BIN too small for N_DIG");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_SHIFT   = 3'd2,
    S_CORRECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bcd;
  logic [W_BIN-1:0] r_bin;
  logic [W_BIN-1:0] r_out;
  logic             r_done;
  logic             r_busy;
  logic             r_err;

  function automatic logic f_bad(input logic [BW-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < N_DIG; i++)
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Digits that picked up a shifted-in 8 really hold 5 more: take 3 back.
  function automatic logic [BW-1:0] f_fix(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < N_DIG; i++)
      if (b[4*i +: 4] >= 4'd8) r[4*i +: 4] = b[4*i +: 4] - 4'd3;
    return r;
  endfunction

  logic w_bad;
  assign w_bad = f_bad(r_bcd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_init) begin
            r_bcd   <= in_BCD;
            r_bin   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_bad) begin
            r_err   <= 1'b1;
            r_out   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {r_bcd, r_bin} >> 1;
          r_state        <= S_CORRECT;
        end
        S_CORRECT: begin
          r_bcd <= f_fix(r_bcd);
          if (r_cnt == LAST) begin
            r_out   <= r_bin;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_BIN  = r_out;
  assign out_DONE = r_done;
  assign out_BUSY = r_busy;
  assign out_ERR  = r_err;

endmodule
